// File: rtl/joy_db15_responder.sv
// Device-side DB15 joystick adapter: answers the reader's LOAD/CLK poll and
// serialises two players' buttons on joy_data, like a 74HC165 chain.
module joy_db15_responder #(
   parameter int NBITS       = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     joy_clk,
   input  logic                     joy_load,
   input  logic [11:0]              joy1_in,
   input  logic [11:0]              joy2_in,
   output logic                     joy_data,
   output logic [$clog2(NBITS)-1:0] bit_cnt,
   output logic                     frame_done,
   output logic                     busy
);

   localparam int              CW       = $clog2(NBITS);
   localparam logic [CW-1:0]   LAST_BIT = CW'(NBITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] load_sync;
   logic                   clk_prev;
   logic [NBITS-1:0]       shreg;
   logic [NBITS-1:0]       shreg_next;
   logic [NBITS-1:0]       frame_word;
   logic                   clk_rise;
   logic                   load_low;

   // Pins idle high, so the synchronisers reset to 1 and no false edge appears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync  <= '1;
         load_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk};
         load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign clk_rise   = clk_sync[SYNC_STAGES-1] & ~clk_prev;
   assign load_low   = ~load_sync[SYNC_STAGES-1];
   assign shreg_next = {1'b1, shreg[NBITS-1:1]};

   always_comb begin
      frame_word        = '1;
      frame_word[23:0]  = {~joy2_in, ~joy1_in};
   end

   // Load has priority over everything, mirroring the 165's SH/LD pin.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         shreg      <= '1;
         joy_data   <= 1'b1;
         bit_cnt    <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (load_low) begin
            state    <= LOAD;
            shreg    <= frame_word;
            joy_data <= frame_word[0];
            bit_cnt  <= '0;
            busy     <= 1'b0;
         end else begin
            case (state)
               LOAD: begin
                  state <= SHIFT;
                  busy  <= 1'b1;
               end
               SHIFT: begin
                  if (clk_rise) begin
                     shreg    <= shreg_next;
                     joy_data <= shreg_next[0];
                     if (bit_cnt == LAST_BIT) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  // Clocks outside a frame keep shifting in 1s; the index saturates.
                  state <= IDLE;
                  if (clk_rise) begin
                     shreg    <= shreg_next;
                     joy_data <= shreg_next[0];
                     if (bit_cnt != LAST_BIT) begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_joy_db15_responder.sv
// Bench for joy_db15_responder: directed scenarios plus random frames, all
// compared every cycle against a frame-snapshot/index model of the adapter.
module tb_joy_db15_responder;

   localparam int NBITS = 24;
   localparam int S     = 2;
   localparam int CW    = $clog2(NBITS);

   logic          clk = 1'b0;
   logic          reset_n;
   logic          joy_clk;
   logic          joy_load;
   logic [11:0]   joy1_in;
   logic [11:0]   joy2_in;
   logic          joy_data;
   logic [CW-1:0] bit_cnt;
   logic          frame_done;
   logic          busy;

   int checks   = 0;
   int errors   = 0;
   int fd_count = 0;
   int fd0;
   bit cmp_en   = 1'b0;

   // Model: frame snapshot, number of rises since load, and a coarse mode.
   logic [NBITS-1:0] m_snap;
   int               m_idx;
   int               m_mode;
   logic             m_fd;
   logic             chist [0:S];
   logic             lhist [0:S];

   joy_db15_responder #(.NBITS(NBITS), .SYNC_STAGES(S)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .joy_clk    (joy_clk),
      .joy_load   (joy_load),
      .joy1_in    (joy1_in),
      .joy2_in    (joy2_in),
      .joy_data   (joy_data),
      .bit_cnt    (bit_cnt),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [NBITS-1:0] frame_of(input logic [11:0] j1, input logic [11:0] j2);
      logic [NBITS-1:0] f;
      f = '1;
      for (int i = 0; i < 12; i++) begin
         f[i]      = ~j1[i];
         f[12 + i] = ~j2[i];
      end
      return f;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pins reach the model S edges late, exactly as through the synchroniser.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k <= S; k++) begin
            chist[k] = 1'b1;
            lhist[k] = 1'b1;
         end
         m_snap = '1;
         m_idx  = 0;
         m_mode = 0;
         m_fd   = 1'b0;
      end else begin
         m_fd = 1'b0;
         if (!lhist[S-1]) begin
            m_mode = 1;
            m_snap = frame_of(joy1_in, joy2_in);
            m_idx  = 0;
         end else if (m_mode == 1) begin
            m_mode = 2;
         end else if (chist[S-1] && !chist[S]) begin
            if (m_idx < NBITS) m_idx++;
            if (m_mode == 2 && m_idx == NBITS) begin
               m_fd   = 1'b1;
               m_mode = 0;
            end
         end
         for (int k = S; k > 0; k--) begin
            chist[k] = chist[k-1];
            lhist[k] = lhist[k-1];
         end
         chist[0] = joy_clk;
         lhist[0] = joy_load;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check_output("joy_data", 32'(joy_data), (m_idx < NBITS) ? 32'(m_snap[m_idx]) : 32'd1);
         check_output("bit_cnt", 32'(bit_cnt), (m_idx < NBITS) ? 32'(m_idx) : 32'(NBITS - 1));
         check_output("frame_done", 32'(frame_done), 32'(m_fd));
         check_output("busy", 32'(busy), (m_mode == 2) ? 32'd1 : 32'd0);
      end
      if (frame_done === 1'b1) fd_count++;
   end

   task automatic clock_rise(input int h);
      joy_clk = 1'b1;
      repeat (h) @(negedge clk);
      joy_clk = 1'b0;
      repeat (h) @(negedge clk);
   endtask

   task automatic rises(input int n, input int h);
      repeat (n) clock_rise(h);
   endtask

   task automatic load_pulse(input int hold);
      joy_load = 1'b0;
      repeat (hold) @(negedge clk);
      joy_load = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      reset_n  = 1'b0;
      joy_clk  = 1'b0;
      joy_load = 1'b1;
      joy1_in  = '0;
      joy2_in  = '0;
      repeat (3) @(negedge clk);
      check_output("rst_joy_data", 32'(joy_data), 32'd1);
      check_output("rst_bit_cnt", 32'(bit_cnt), 32'd0);
      check_output("rst_frame_done", 32'(frame_done), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      cmp_en  = 1'b1;
      repeat (2) @(negedge clk);

      // Only player 1 R pressed: a single 0 then 23 ones.
      joy1_in = 12'h001;
      load_pulse(3);
      check_output("t1_bit0", 32'(joy_data), 32'd0);
      check_output("t1_busy", 32'(busy), 32'd1);
      fd0 = fd_count;
      for (int i = 1; i < NBITS; i++) begin
         clock_rise(4);
         check_output("t1_bit", 32'(joy_data), 32'd1);
         check_output("t1_cnt", 32'(bit_cnt), 32'(i));
      end
      clock_rise(4);
      check_output("t1_done_pulses", 32'(fd_count - fd0), 32'd1);
      check_output("t1_busy_end", 32'(busy), 32'd0);

      // Only player 2 top button pressed: bit 23 alone is low.
      joy1_in = 12'h000;
      joy2_in = 12'h800;
      load_pulse(2);
      for (int i = 0; i < NBITS; i++) begin
         check_output("t2_bit", 32'(joy_data), (i == NBITS - 1) ? 32'd0 : 32'd1);
         check_output("t2_cnt", 32'(bit_cnt), 32'(i));
         clock_rise(3);
      end
      joy2_in = 12'h000;

      // Clocks during a held load are ignored.
      joy1_in  = 12'h003;
      joy_load = 1'b0;
      repeat (3) @(negedge clk);
      rises(5, 3);
      check_output("t3_hold_data", 32'(joy_data), 32'd0);
      check_output("t3_hold_cnt", 32'(bit_cnt), 32'd0);
      joy_load = 1'b1;
      repeat (4) @(negedge clk);
      check_output("t3_bit0", 32'(joy_data), 32'd0);
      clock_rise(4);
      check_output("t3_bit1", 32'(joy_data), 32'd0);
      clock_rise(4);
      check_output("t3_bit2", 32'(joy_data), 32'd1);
      rises(22, 3);

      // Abort after 10 rises: fresh frame, no pulse for the aborted one.
      joy1_in = 12'h5A5;
      load_pulse(2);
      rises(10, 3);
      fd0 = fd_count;
      load_pulse(2);
      check_output("t4_cnt", 32'(bit_cnt), 32'd0);
      check_output("t4_bit0", 32'(joy_data), 32'd0);
      check_output("t4_no_pulse", 32'(fd_count - fd0), 32'd0);
      rises(NBITS, 3);
      check_output("t4_one_pulse", 32'(fd_count - fd0), 32'd1);

      // Inputs changing mid-frame do not leak into the frame.
      joy1_in = 12'h0A5;
      load_pulse(2);
      rises(3, 3);
      joy1_in = 12'hFFF;
      joy2_in = 12'hFFF;
      rises(2, 4);
      check_output("t5_bit5", 32'(joy_data), 32'd0);
      clock_rise(4);
      check_output("t5_bit6", 32'(joy_data), 32'd1);
      rises(18, 3);
      joy2_in = 12'h000;

      // Asynchronous reset at bit 7, then overclocking after a full frame.
      joy1_in = 12'h080;
      load_pulse(2);
      rises(7, 3);
      check_output("t6_bit7", 32'(joy_data), 32'd0);
      check_output("t6_busy", 32'(busy), 32'd1);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_output("t6_rst_data", 32'(joy_data), 32'd1);
      check_output("t6_rst_busy", 32'(busy), 32'd0);
      check_output("t6_rst_cnt", 32'(bit_cnt), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      joy1_in = 12'h001;
      load_pulse(2);
      fd0 = fd_count;
      rises(NBITS + 30, 3);
      check_output("t6_extra_pulses", 32'(fd_count - fd0), 32'd1);
      check_output("t6_extra_data", 32'(joy_data), 32'd1);
      check_output("t6_extra_cnt", 32'(bit_cnt), 32'(NBITS - 1));

      // Random frames, aborts, mid-frame input churn and stray clocks.
      for (int it = 0; it < 25; it++) begin
         joy1_in = 12'($urandom);
         joy2_in = 12'($urandom);
         if ($urandom_range(0, 5) != 0) load_pulse($urandom_range(1, 5));
         for (int j = 0; j < int'($urandom_range(0, 32)); j++) begin
            if ($urandom_range(0, 7) == 0) joy1_in = 12'($urandom);
            clock_rise($urandom_range(2, 5));
         end
      end

      repeat (5) @(negedge clk);
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
